// File: rtl/synth_pkg.sv
//------------------------------------------------------------------------------
// synth_pkg: constants and types shared by the synth core, spi and sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package synth_pkg;
  localparam int CNT_W = 12;

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} seq_state_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;
endpackage

`default_nettype wire

// File: rtl/step_sequencer_tick.sv
//------------------------------------------------------------------------------
// seq_tick: per-step tick counter with period and gate-length compares.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_tick #(
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run_en,
  input  logic               restart,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [7:0]         swing_amt,
  output logic               step_end,
  output logic               gate_off
);
  localparam logic [TEMPO_W:0] C_ONE = {{TEMPO_W{1'b0}}, 1'b1};

  logic [TEMPO_W:0] tick_q, tick_d;
  logic [TEMPO_W:0] tick_inc;
  logic [TEMPO_W:0] period;

  // Magnitude compares rather than equality so a live tempo/gate decrease
  // below the current tick still ends the step instead of wrapping around.
  always_comb begin
    period = {1'b0, tempo_div};
    if (tempo_div == '0) begin
      period = C_ONE;
    end
    period   = period + {{(TEMPO_W-7){1'b0}}, swing_amt};
    tick_inc = tick_q + C_ONE;
    step_end = (tick_q >= (period - C_ONE));
    gate_off = (tick_inc >= {1'b0, gate_len});
    tick_d   = (run_en && !restart) ? tick_inc : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/step_sequencer.sv
//------------------------------------------------------------------------------
// step_sequencer: STEPS-entry note pattern player driving synth trig/osc_count.
// Optional SEQ_SWING_EN adds a swing input lengthening odd-indexed steps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_sequencer #(
  parameter  int STEPS   = 8,
  parameter  int CNT_W   = synth_pkg::CNT_W,
  parameter  int TEMPO_W = 24,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [AW-1:0]      last_step,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CNT_W-1:0]   wr_note,
  input  logic               wr_rest,
`ifdef SEQ_SWING_EN
  input  logic [7:0]         swing,
`endif
  output logic [CNT_W-1:0]   osc_count,
  output logic               trig,
  output logic [AW-1:0]      step_idx,
  output logic               step_strobe
);
  import synth_pkg::*;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] note_q [STEPS];
  logic [CNT_W-1:0] note_d [STEPS];
  logic [STEPS-1:0] rest_q, rest_d;
  logic [CNT_W-1:0] osc_q, osc_d;
  logic             trig_q, trig_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             strobe_q, strobe_d;

  logic             load;
  logic [AW-1:0]    next_idx;
  logic [CNT_W-1:0] load_note;
  logic             load_rest;
  logic             run_en;
  logic             step_end;
  logic             gate_off;
  logic [7:0]       swing_amt;

`ifdef SEQ_SWING_EN
  assign swing_amt = idx_q[0] ? swing : 8'd0;
`else
  assign swing_amt = 8'd0;
`endif

  assign run_en = (state_q == ST_PLAY) && run;

  seq_tick #(.TEMPO_W(TEMPO_W)) u_tick (
    .clk       (clk),
    .rstn      (rstn),
    .run_en    (run_en),
    .restart   (load),
    .tempo_div (tempo_div),
    .gate_len  (gate_len),
    .swing_amt (swing_amt),
    .step_end  (step_end),
    .gate_off  (gate_off)
  );

  always_comb begin
    note_d = note_q;
    rest_d = rest_q;
    if (wr_en) begin
      note_d[wr_addr] = wr_note;
      rest_d[wr_addr] = wr_rest;
    end
  end

  always_comb begin
    state_d  = state_q;
    osc_d    = osc_q;
    trig_d   = trig_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    next_idx = '0;
    case (state_q)
      ST_IDLE: begin
        trig_d = 1'b0;
        idx_d  = '0;
        if (run) begin
          state_d = ST_PLAY;
          load    = 1'b1;
        end
      end
      default: begin
        if (!run) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
          idx_d   = '0;
        end else if (step_end) begin
          load     = 1'b1;
          // >= so a last_step lowered below the playing step wraps to 0
          next_idx = (idx_q >= last_step) ? '0 : idx_q + AW'(1);
        end else if (gate_off) begin
          trig_d = 1'b0;
        end
      end
    endcase

    // A write on the load edge of the same entry is forwarded.
    load_note = (wr_en && (wr_addr == next_idx)) ? wr_note : note_q[next_idx];
    load_rest = (wr_en && (wr_addr == next_idx)) ? wr_rest : rest_q[next_idx];
    if (load) begin
      osc_d    = load_note;
      idx_d    = next_idx;
      trig_d   = !load_rest && (gate_len != '0);
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      osc_q    <= '0;
      trig_q   <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      rest_q   <= '1;
      for (int i = 0; i < STEPS; i++) begin
        note_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      osc_q    <= osc_d;
      trig_q   <= trig_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      rest_q   <= rest_d;
      note_q   <= note_d;
    end
  end

  assign osc_count   = osc_q;
  assign trig        = trig_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;
endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
//------------------------------------------------------------------------------
// tb_step_sequencer: scoreboard bench for step_sequencer (SEQ_SWING_EN optional).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_step_sequencer;
  localparam int AW = 3;
  localparam int CW = 12;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          run = 1'b0;
  logic [TW-1:0] tempo_div = '0;
  logic [TW-1:0] gate_len = '0;
  logic [AW-1:0] last_step = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_note = '0;
  logic          wr_rest = 1'b0;
`ifdef SEQ_SWING_EN
  logic [7:0]    swing = '0;
`endif
  logic [CW-1:0] osc_count;
  logic          trig;
  logic [AW-1:0] step_idx;
  logic          step_strobe;

  typedef struct packed {
    logic [CW-1:0] osc;
    logic          trig;
    logic [AW-1:0] idx;
    logic          stb;
  } obs_t;

  obs_t          exp_q[$];
  obs_t          got, exp_v;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] notes_m [8];
  logic          rests_m [8];

  step_sequencer dut (
    .clk         (clk),
    .rstn        (rstn),
    .run         (run),
    .tempo_div   (tempo_div),
    .gate_len    (gate_len),
    .last_step   (last_step),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_note     (wr_note),
    .wr_rest     (wr_rest),
`ifdef SEQ_SWING_EN
    .swing       (swing),
`endif
    .osc_count   (osc_count),
    .trig        (trig),
    .step_idx    (step_idx),
    .step_strobe (step_strobe)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{osc: osc_count, trig: trig, idx: step_idx, stb: step_strobe};
  endfunction

  // Expected per-cycle outputs from the start edge, derived from step periods.
  task automatic build_exp(input int n, input int tempo, input int gate,
                           input int last, input int sw);
    int s = 0;
    int k = 0;
    int per;
    obs_t e;
    while (k < n) begin
      per = ((tempo == 0) ? 1 : tempo) + ((s % 2 == 1) ? sw : 0);
      for (int j = 0; j < per && k < n; j++) begin
        e.osc  = notes_m[s];
        e.trig = !rests_m[s] && (j < gate);
        e.idx  = AW'(s);
        e.stb  = (j == 0);
        exp_q.push_back(e);
        k++;
      end
      s = (s == last) ? 0 : s + 1;
    end
  endtask

  task automatic write_entry(input int addr, input int note, input logic rest);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_note = CW'(note); wr_rest = rest;
    notes_m[addr] = CW'(note); rests_m[addr] = rest;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    got = sample();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got osc=%0d trig=%0b idx=%0d stb=%0b required all 0",
               got.osc, got.trig, got.idx, got.stb);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_pattern();
    write_entry(0, 100, 1'b0);
    write_entry(1, 200, 1'b0);
    write_entry(2, 300, 1'b0);
    write_entry(3, 400, 1'b0);
    last_step = 3; tempo_div = 10; gate_len = 4;
    build_exp(45, 10, 4, 3, 0);
    run = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL pattern k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
    end
    @(negedge clk);
    run = 1'b0;
    @(posedge clk); #1;
    got = sample(); n_checks++;
    if (got !== obs_t'{osc: 12'd100, trig: 1'b0, idx: '0, stb: 1'b0}) begin
      n_fail++;
      $display("FAIL stop got osc=%0d trig=%0b idx=%0d stb=%0b required osc=100 trig=0 idx=0 stb=0",
               got.osc, got.trig, got.idx, got.stb);
    end
  endtask

  task automatic test_rest();
    write_entry(2, 300, 1'b1);
    tempo_div = 10; gate_len = 20;
    build_exp(45, 10, 20, 3, 0);
    @(negedge clk);
    run = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rest_legato k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
    end
    stop_run();
  endtask

  task automatic test_fast();
    tempo_div = 0; gate_len = 0;
    build_exp(12, 0, 0, 3, 0);
    run = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL fast k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
    end
    stop_run();
  endtask

  task automatic test_bypass();
    tempo_div = 10; gate_len = 4;
    notes_m[1] = 12'd555; rests_m[1] = 1'b0;
    build_exp(25, 10, 4, 3, 0);
    run = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL bypass k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
      // Write lands on the edge that loads step 1
      if (k == 9) begin
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_note = 12'd555; wr_rest = 1'b0;
      end else if (k == 10) begin
        @(negedge clk);
        wr_en = 1'b0;
      end
    end
    stop_run();
  endtask

`ifdef SEQ_SWING_EN
  task automatic test_swing();
    tempo_div = 10; gate_len = 4; swing = 8'd5;
    build_exp(60, 10, 4, 3, 5);
    run = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL swing k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
    end
    stop_run();
    swing = 8'd0;
  endtask
`endif

  task automatic test_async_reset();
    tempo_div = 10; gate_len = 4;
    run = 1'b1;
    repeat (13) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    got = sample(); n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset got osc=%0d trig=%0b idx=%0d stb=%0b required all 0",
               got.osc, got.trig, got.idx, got.stb);
    end
    run = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      notes_m[i] = '0; rests_m[i] = 1'b1;
    end
    build_exp(24, 10, 4, 3, 0);
    @(negedge clk);
    run = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      got = sample(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL cleared_pattern k=%0d got osc=%0d trig=%0b idx=%0d stb=%0b required osc=%0d trig=%0b idx=%0d stb=%0b",
                 k, got.osc, got.trig, got.idx, got.stb, exp_v.osc, exp_v.trig, exp_v.idx, exp_v.stb);
      end
    end
    stop_run();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      notes_m[i] = '0; rests_m[i] = 1'b1;
    end
    test_reset();
    test_pattern();
    test_rest();
    test_fast();
    test_bypass();
`ifdef SEQ_SWING_EN
    test_swing();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
